backlight_pwm_dimmer: RTL and testbench

- Consumes the 8-bit real-time backlight brightness value produced by the ambient-light (AP3216) processing stage.
- Converts that value into a glitch-free PWM drive for the MiniLED backlight.
- Duty changes are applied only at PWM period boundaries and are slew-limited per period.
- A global enable performs a soft ramp-up and ramp-down so the panel never snaps on or off.

---
 rtl/backlight_pwm_dimmer.sv | 162 ++++++++++++++++
 tb/tb_backlight_pwm_dimmer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/backlight_pwm_dimmer.sv
// -----------------------------------------------------------------------------
// backlight_pwm_dimmer
//
// Turns the 8-bit ambient-light brightness value into a glitch-free PWM drive
// for the MiniLED backlight. Duty changes take effect only at PWM period
// boundaries. Each change is slew-limited to STEP LSBs per period. The enable
// input ramps the duty up or down softly, so the panel never snaps on or off.
//
// Ports:
//   I_clk          system clock
//   I_reset        synchronous reset, active-high
//   I_en           backlight enable (level)
//   I_bright_data  requested brightness, sampled only at a period boundary
//   O_pwm          registered PWM drive; lags the phase counter by one cycle
//   O_duty         duty currently applied
//   O_period_start one-cycle pulse on the first cycle of each PWM period
//   O_busy         high while ramping (RAMP or DOWN state)
//
// Handshake: there is none. The inputs are level signals. They are sampled
// only on the boundary cycle. The outputs are plain registered levels or
// pulses.
// -----------------------------------------------------------------------------
module backlight_pwm_dimmer #(
    parameter int PRESC_DIV = 10,
    parameter int STEP      = 2,
    parameter int MIN_DUTY  = 4
) (
    input  logic       I_clk,
    input  logic       I_reset,
    input  logic       I_en,
    input  logic [7:0] I_bright_data,
    output logic       O_pwm,
    output logic [7:0] O_duty,
    output logic       O_period_start,
    output logic       O_busy
);

    localparam logic [15:0] PRESC_L = 16'(PRESC_DIV - 1);
    localparam logic [7:0]  STEP_L  = 8'(STEP);
    localparam logic [7:0]  MIN_L   = 8'(MIN_DUTY);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_presc;
    logic [7:0]  r_phase;
    logic [7:0]  r_duty;
    logic        r_pwm;
    logic        r_period_start;
    logic        r_busy;

    logic        w_tick;
    logic        w_boundary;
    logic [7:0]  w_target;
    logic [8:0]  w_up9;
    logic [8:0]  w_dn9;
    logic [7:0]  w_next_duty;

    assign w_tick     = (r_presc == PRESC_L);
    // A period ends on the tick that wraps the phase from 255 to 0.
    assign w_boundary = w_tick && (r_phase == 8'hFF);

    // Target and slew-limited duty. The 9-bit intermediates keep the step
    // from wrapping past 0 or 255.
    always_comb begin
        w_target    = 8'd0;
        w_up9       = {1'b0, r_duty} + {1'b0, STEP_L};
        w_dn9       = {1'b0, r_duty} - {1'b0, STEP_L};
        w_next_duty = r_duty;
        if (I_en) begin
            w_target = (I_bright_data < MIN_L) ? MIN_L : I_bright_data;
        end
        if (r_duty < w_target) begin
            w_next_duty = (w_up9 > {1'b0, w_target}) ? w_target : w_up9[7:0];
        end else if (r_duty > w_target) begin
            // A set bit 8 means the subtraction underflowed below zero.
            w_next_duty = (w_dn9[8] || (w_dn9 < {1'b0, w_target})) ? w_target : w_dn9[7:0];
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_state        <= ST_OFF;
            r_presc        <= 16'd0;
            r_phase        <= 8'd0;
            r_duty         <= 8'd0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_period_start <= w_boundary;

            if (w_tick) begin
                r_presc <= 16'd0;
                r_phase <= r_phase + 8'd1;
            end else begin
                r_presc <= r_presc + 16'd1;
            end

            // On the boundary edge this compares phase 255 against the old
            // duty. The new duty first shows up on O_pwm for phase 0.
            r_pwm <= (r_duty == 8'hFF) || (r_phase < r_duty);

            if (w_boundary) begin
                r_duty <= w_next_duty;
                case (r_state)
                    ST_OFF: begin
                        if (I_en) begin
                            r_state <= ST_RAMP;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_RAMP: begin
                        if (!I_en) begin
                            r_state <= ST_DOWN;
                            r_busy  <= 1'b1;
                        end else if (w_next_duty == w_target) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (!I_en) begin
                            r_state <= ST_DOWN;
                            r_busy  <= 1'b1;
                        end else if (w_target != r_duty) begin
                            r_state <= ST_RAMP;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_DOWN: begin
                        // Re-enabling continues from the current duty,
                        // because the step logic moves it toward the new
                        // target.
                        if (I_en) begin
                            r_state <= ST_RAMP;
                            r_busy  <= 1'b1;
                        end else if (w_next_duty == 8'd0) begin
                            r_state <= ST_OFF;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_OFF;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign O_pwm          = r_pwm;
    assign O_duty         = r_duty;
    assign O_period_start = r_period_start;
    assign O_busy         = r_busy;

endmodule

// File: tb/tb_backlight_pwm_dimmer.sv
// -----------------------------------------------------------------------------
// Testbench for backlight_pwm_dimmer (PRESC_DIV=1, STEP=2, MIN_DUTY=4).
// The driver pushes the {busy, duty} pair it expects after each boundary.
// The monitor pops one entry on every O_period_start and compares it. The
// monitor also checks the O_pwm high count of the period that just ended
// against the duty expected for that period.
// -----------------------------------------------------------------------------
module tb_backlight_pwm_dimmer;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] bright;
  logic       o_pwm;
  logic [7:0] o_duty;
  logic       o_period_start;
  logic       o_busy;

  int vectors_applied = 0;
  int miscompares     = 0;

  logic [8:0] exp_q[$];

  backlight_pwm_dimmer #(
    .PRESC_DIV(1),
    .STEP(2),
    .MIN_DUTY(4)
  ) dut (
    .I_clk(clk),
    .I_reset(reset),
    .I_en(en),
    .I_bright_data(bright),
    .O_pwm(o_pwm),
    .O_duty(o_duty),
    .O_period_start(o_period_start),
    .O_busy(o_busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input int obs, input int exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         hi_cnt  = 0;
  bit         have_prev = 0;
  logic [7:0] prev_d  = 8'd0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) begin
      hi_cnt    = 0;
      have_prev = 0;
    end else begin
      hi_cnt = hi_cnt + int'(o_pwm);
      if (o_period_start) begin
        if (have_prev)
          check("pwm_hi_cnt", hi_cnt, (prev_d == 8'hFF) ? 256 : int'(prev_d));
        hi_cnt = 0;
        if (exp_q.size() == 0) begin
          check("sb_depth", exp_q.size(), 1);
          have_prev = 0;
        end else begin
          e = exp_q.pop_front();
          check("duty", o_duty, e[7:0]);
          check("busy", o_busy, e[8]);
          prev_d    = e[7:0];
          have_prev = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ps();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_period_start && n < 400);
    if (!o_period_start) check("ps_timeout", n, 256);
  endtask

  task automatic expect_period(input int d, input bit b);
    exp_q.push_back({b, 8'(d)});
    wait_ps();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset  = 1'b1;
    en     = 1'b0;
    bright = 8'd0;
    repeat (4) @(negedge clk);
    check("rst_pwm", o_pwm, 0);
    check("rst_duty", o_duty, 0);
    check("rst_ps", o_period_start, 0);
    check("rst_busy", o_busy, 0);

    // Ramp from reset up to 100.
    reset  = 1'b0;
    en     = 1'b1;
    bright = 8'd100;
    for (int k = 1; k <= 50; k++) expect_period(2 * k, k < 50);
    expect_period(100, 0);

    // Disable, then re-enable at duty 60 toward 64.
    en = 1'b0;
    for (int k = 1; k <= 20; k++) expect_period(100 - 2 * k, 1);
    en     = 1'b1;
    bright = 8'd64;
    expect_period(62, 1);
    expect_period(64, 0);
    en = 1'b0;
    for (int k = 1; k <= 32; k++) expect_period(64 - 2 * k, k < 32);
    expect_period(0, 0);

    // Brightness 0 is clamped up to MIN_DUTY.
    en     = 1'b1;
    bright = 8'd0;
    expect_period(2, 1);
    expect_period(4, 0);
    expect_period(4, 0);

    // A small change is capped at the target; busy pulses for one period.
    bright = 8'd5;
    expect_period(5, 1);
    expect_period(5, 0);

    // Full brightness, then 254.
    bright = 8'd255;
    for (int k = 1; k <= 125; k++) expect_period(5 + 2 * k, k < 125);
    expect_period(255, 0);
    expect_period(255, 0);
    bright = 8'd254;
    expect_period(254, 1);
    expect_period(254, 0);
    expect_period(254, 0);

    // Reset in mid-period while the output is high.
    repeat (128) @(negedge clk);
    check("pre_rst_pwm", o_pwm, 1);
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    check("mid_rst_pwm", o_pwm, 0);
    check("mid_rst_duty", o_duty, 0);
    check("mid_rst_ps", o_period_start, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_q", exp_q.size(), 0);
    exp_q.push_back(9'h000);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_period_start && n < 400);
    check("rst_to_ps", n, 256);
    expect_period(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
